// File: rtl/divider_arbiter.sv
// Round-robin front end that time-shares one combinational divider between NUM_REQ clients.
// One operation in flight: accept (IDLE) -> drive divider (EXEC) -> hold result until taken (RESP).
module divider_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    localparam int IDW       = $clog2(NUM_REQ)
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [NUM_REQ-1:0]            req_valid_in,
    output logic [NUM_REQ-1:0]            req_ready_out,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_numerator_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_denominator_in,
    output logic                          resp_valid_out,
    input  logic                          resp_ready_in,
    output logic [IDW-1:0]                resp_id_out,
    output logic [DATA_WIDTH-1:0]         resp_quotient_out,
    output logic [DATA_WIDTH-1:0]         resp_remainder_out,
    output logic                          resp_div_zero_out,
    output logic [DATA_WIDTH-1:0]         div_numerator_out,
    output logic [DATA_WIDTH-1:0]         div_denominator_out,
    output logic                          div_enable_out,
    input  logic [DATA_WIDTH-1:0]         div_quotient_in,
    input  logic [DATA_WIDTH-1:0]         div_remainder_in
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [IDW-1:0]        rr_ptr;
    logic [IDW-1:0]        grant_id;
    logic [IDW-1:0]        search_idx;
    logic                  grant_found;
    logic                  accept;
    logic                  resp_fire;
    logic [DATA_WIDTH-1:0] grant_num;
    logic [DATA_WIDTH-1:0] grant_den;

    // Rotating priority search starting at rr_ptr.
    // NOTE: every variable written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        search_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            search_idx = IDW'((int'(rr_ptr) + k) % NUM_REQ);
            if (!grant_found && req_valid_in[search_idx]) begin
                grant_found = 1'b1;
                grant_id    = search_idx;
            end
        end
    end

    assign accept    = (state == IDLE) && grant_found;
    assign resp_fire = resp_valid_out && resp_ready_in;
    assign grant_num = req_numerator_in[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
    assign grant_den = req_denominator_in[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        req_ready_out = '0;
        if (accept) begin
            req_ready_out[grant_id] = 1'b1;
        end
    end

    assign resp_valid_out = (state == RESP);
    assign div_enable_out = (state == EXEC);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = (grant_den == '0) ? RESP : EXEC;
            EXEC: state_nxt = RESP;
            RESP: if (resp_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state               <= IDLE;
            rr_ptr              <= '0;
            resp_id_out         <= '0;
            resp_quotient_out   <= '0;
            resp_remainder_out  <= '0;
            resp_div_zero_out   <= 1'b0;
            div_numerator_out   <= '0;
            div_denominator_out <= '0;
        end else begin
            state <= state_nxt;

            if (accept) begin
                resp_id_out <= grant_id;
                if (grant_den == '0) begin
                    // Divider is bypassed; divider operands keep their previous value.
                    resp_quotient_out  <= '1;
                    resp_remainder_out <= grant_num;
                    resp_div_zero_out  <= 1'b1;
                end else begin
                    div_numerator_out   <= grant_num;
                    div_denominator_out <= grant_den;
                    resp_div_zero_out   <= 1'b0;
                end
            end

            if (state == EXEC) begin
                resp_quotient_out  <= div_quotient_in;
                resp_remainder_out <= div_remainder_in;
            end

            // Priority only rotates once the response has actually been consumed.
            if (resp_fire) begin
                rr_ptr <= (resp_id_out == IDW'(NUM_REQ - 1)) ? '0 : resp_id_out + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_divider_arbiter.sv
// Randomized bench for divider_arbiter: transaction-level model predicts grants, latency and results.
module tb_divider_arbiter;

    localparam int DW  = 8;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic            clk_in = 1'b0;
    logic            rst_in;
    logic [N-1:0]    req_valid_in;
    logic [N-1:0]    req_ready_out;
    logic [N*DW-1:0] req_numerator_in;
    logic [N*DW-1:0] req_denominator_in;
    logic            resp_valid_out;
    logic            resp_ready_in;
    logic [IDW-1:0]  resp_id_out;
    logic [DW-1:0]   resp_quotient_out;
    logic [DW-1:0]   resp_remainder_out;
    logic            resp_div_zero_out;
    logic [DW-1:0]   div_numerator_out;
    logic [DW-1:0]   div_denominator_out;
    logic            div_enable_out;
    logic [DW-1:0]   div_quotient_in;
    logic [DW-1:0]   div_remainder_in;

    divider_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N)) dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .req_valid_in        (req_valid_in),
        .req_ready_out       (req_ready_out),
        .req_numerator_in    (req_numerator_in),
        .req_denominator_in  (req_denominator_in),
        .resp_valid_out      (resp_valid_out),
        .resp_ready_in       (resp_ready_in),
        .resp_id_out         (resp_id_out),
        .resp_quotient_out   (resp_quotient_out),
        .resp_remainder_out  (resp_remainder_out),
        .resp_div_zero_out   (resp_div_zero_out),
        .div_numerator_out   (div_numerator_out),
        .div_denominator_out (div_denominator_out),
        .div_enable_out      (div_enable_out),
        .div_quotient_in     (div_quotient_in),
        .div_remainder_in    (div_remainder_in)
    );

    always #5 clk_in = ~clk_in;

    // Divider stand-in: returns junk unless enabled, so results taken at the wrong time show up.
    always_comb begin
        div_quotient_in  = 8'hA5;
        div_remainder_in = 8'h5A;
        if (div_enable_out && div_denominator_out != '0) begin
            div_quotient_in  = div_numerator_out / div_denominator_out;
            div_remainder_in = div_numerator_out % div_denominator_out;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Requester side
    bit            vld  [N];
    logic [DW-1:0] mnum [N];
    logic [DW-1:0] mden [N];

    // Transaction model
    bit            busy;
    int            age;
    int            op_id;
    logic [DW-1:0] op_num;
    logic [DW-1:0] op_den;
    int            rr;
    bit            expect_zero;
    int            served;

    task automatic check_all_zero();
        check("rst_resp_valid", resp_valid_out, 0);
        check("rst_resp_id", resp_id_out, 0);
        check("rst_quotient", resp_quotient_out, 0);
        check("rst_remainder", resp_remainder_out, 0);
        check("rst_div_zero", resp_div_zero_out, 0);
        check("rst_div_num", div_numerator_out, 0);
        check("rst_div_den", div_denominator_out, 0);
        check("rst_div_en", div_enable_out, 0);
    endtask

    task automatic step(input bit rst_now, input int p_valid, input int p_drop,
                        input int p_ready, input int p_zero);
        logic [N-1:0]  exp_ready;
        logic [DW-1:0] exp_q;
        logic [DW-1:0] exp_r;
        int            g;
        int            idx;
        bit            in_exec;
        bit            in_resp;
        @(negedge clk_in);
        for (int i = 0; i < N; i++) begin
            if (!vld[i]) begin
                if ($urandom_range(99) < p_valid) begin
                    vld[i]  = 1'b1;
                    mnum[i] = DW'($urandom);
                    mden[i] = ($urandom_range(99) < p_zero) ? '0 : DW'($urandom_range(255, 1));
                end
            end else if ($urandom_range(99) < p_drop) begin
                vld[i] = 1'b0;
            end
            req_valid_in[i]                  = vld[i];
            req_numerator_in[i*DW +: DW]     = mnum[i];
            req_denominator_in[i*DW +: DW]   = mden[i];
        end
        rst_in        = rst_now;
        resp_ready_in = ($urandom_range(99) < p_ready);
        #1;
        if (expect_zero) begin
            check_all_zero();
            expect_zero = 1'b0;
        end
        if (!busy) begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                idx = (rr + k) % N;
                if (g < 0 && vld[idx]) g = idx;
            end
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            check("ready_idle", req_ready_out, exp_ready);
            check("resp_valid_idle", resp_valid_out, 0);
            check("div_en_idle", div_enable_out, 0);
            if (g >= 0) begin
                busy   = 1'b1;
                age    = 0;
                op_id  = g;
                op_num = mnum[g];
                op_den = mden[g];
                vld[g] = 1'b0;
            end
        end else begin
            age++;
            in_exec = (op_den != 0) && (age == 1);
            in_resp = (op_den == 0) ? (age >= 1) : (age >= 2);
            check("ready_busy", req_ready_out, 0);
            check("div_en", div_enable_out, in_exec);
            if (in_exec) begin
                check("div_num", div_numerator_out, op_num);
                check("div_den", div_denominator_out, op_den);
            end
            check("resp_valid", resp_valid_out, in_resp);
            if (in_resp) begin
                exp_q = (op_den == 0) ? 8'hFF  : op_num / op_den;
                exp_r = (op_den == 0) ? op_num : op_num % op_den;
                check("resp_id", resp_id_out, op_id);
                check("resp_q", resp_quotient_out, exp_q);
                check("resp_r", resp_remainder_out, exp_r);
                check("resp_dz", resp_div_zero_out, op_den == 0);
                if (resp_ready_in) begin
                    busy = 1'b0;
                    rr   = (op_id + 1) % N;
                    served++;
                end
            end
        end
        if (rst_now) begin
            busy        = 1'b0;
            rr          = 0;
            expect_zero = 1'b1;
        end
    endtask

    task automatic phase(input int cycles, input int p_valid, input int p_drop,
                         input int p_ready, input int p_zero, input int p_rst);
        bit r;
        for (int c = 0; c < cycles; c++) begin
            r = busy && age == 0 && op_den != 0 && ($urandom_range(99) < p_rst);
            step(r, p_valid, p_drop, p_ready, p_zero);
        end
        // Release reset if the last step asserted it.
        if (r) step(1'b0, 0, 0, 100, 0);
    endtask

    initial begin
        rst_in             = 1'b1;
        resp_ready_in      = 1'b0;
        req_valid_in       = '0;
        req_numerator_in   = '0;
        req_denominator_in = '0;
        for (int i = 0; i < N; i++) begin
            vld[i]  = 1'b0;
            mnum[i] = '0;
            mden[i] = '0;
        end
        busy = 1'b0; age = 0; op_id = 0; op_num = '0; op_den = '0;
        rr = 0; expect_zero = 1'b0; served = 0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        check_all_zero();
        check("rst_ready", req_ready_out, 0);

        phase(60,   100, 0, 100, 0,  0);   // every client always requesting, consumer always ready
        phase(3000, 30,  3, 60,  15, 5);   // mixed traffic with zero divisors and mid-op resets
        phase(1500, 80,  2, 15,  25, 3);   // slow consumer with pending requests
        phase(500,  100, 0, 100, 50, 0);

        check("ops_served_nonzero", served > 100, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
